iterative_signed_or_unsigned_mul: RTL

//   Sequential n x n -> 2n multiplier; each operation picks signed or unsigned mode.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_operand_prep.sv | 30 +++
 rtl/iterative_signed_or_unsigned_mul.sv | 107 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative signed/unsigned multiplier.
// abs_n works on a zero-extended operand of any width up to MUL_MAX_W bits.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    localparam int MUL_MAX_W = 64;

    // Magnitude of the w-bit two's-complement value held in the low bits of v.
    // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [MUL_MAX_W-1:0] abs_n(input logic [MUL_MAX_W-1:0] v, input int w);
        logic [MUL_MAX_W-1:0] mask;
        mask = (w >= MUL_MAX_W) ? '1 : ((MUL_MAX_W'(1) << w) - 1'b1);
        return v[w-1] ? ((~v + 1'b1) & mask) : (v & mask);
    endfunction

endpackage

// File: rtl/mul_operand_prep.sv
// Combinational operand conditioning: turns signed operands into magnitudes
// plus a result-sign flag so the core only ever does an unsigned multiply.
module mul_operand_prep
    import mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         signed_mul,
    output logic [n-1:0] ma,
    output logic [n-1:0] mb,
    output logic         neg
);

    typedef logic [n-1:0] op_t;

    // NOTE: every output gets a default before the if, so no path leaves one unassigned (no latch).
    always_comb begin
        ma  = a;
        mb  = b;
        neg = 1'b0;
        if (signed_mul) begin
            ma  = op_t'(abs_n(MUL_MAX_W'(a), n));
            mb  = op_t'(abs_n(MUL_MAX_W'(b), n));
            neg = a[n-1] ^ b[n-1];
        end
    end

endmodule

// File: rtl/iterative_signed_or_unsigned_mul.sv
// Radix-2 shift-add n x n -> 2n multiplier, one multiplier bit per clock,
// with valid/ready handshakes on both sides and one operation in flight.
module iterative_signed_or_unsigned_mul
    import mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up_valid,
    output logic           up_ready,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           signed_mul,
    output logic           down_valid,
    input  logic           down_ready,
    output logic [2*n-1:0] res
);

    localparam int           W2   = 2 * n;
    localparam int           CW   = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    mul_state_t      r_state;
    logic            r_up_ready;
    logic            r_down_valid;
    logic [W2-1:0]   r_res;
    logic [W2-1:0]   r_acc;
    logic [n-1:0]    r_ma;
    logic [n-1:0]    r_mb;
    logic            r_neg;
    logic [CW-1:0]   r_cnt;

    logic [n-1:0]    w_ma;
    logic [n-1:0]    w_mb;
    logic            w_neg;
    logic [W2-1:0]   w_acc_next;

    mul_operand_prep #(.n(n)) u_prep (
        .a          (a),
        .b          (b),
        .signed_mul (signed_mul),
        .ma         (w_ma),
        .mb         (w_mb),
        .neg        (w_neg)
    );

    assign w_acc_next = r_acc + (r_mb[0] ? (W2'(r_ma) << r_cnt) : '0);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_up_ready   <= 1'b1;
            r_down_valid <= 1'b0;
            r_res        <= '0;
            r_acc        <= '0;
            r_ma         <= '0;
            r_mb         <= '0;
            r_neg        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (up_valid && r_up_ready) begin
                        r_ma       <= w_ma;
                        r_mb       <= w_mb;
                        r_neg      <= w_neg;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_up_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_next;
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    // Last multiplier bit: apply the sign to the completed sum.
                    if (r_cnt == LAST) begin
                        r_res        <= r_neg ? (-w_acc_next) : w_acc_next;
                        r_down_valid <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        r_down_valid <= 1'b0;
                        r_up_ready   <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_up_ready   <= 1'b1;
                    r_down_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign up_ready   = r_up_ready;
    assign down_valid = r_down_valid;
    assign res        = r_res;

endmodule
